// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state encoding and CRC-32 constants for the RMII transmit path
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    FCS,
    GAP
  } state_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          FCS_DIBITS    = 16;

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - reflected CRC-32 next state for one dibit, bit 0 shifted in first
module crc32_dibit
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_next
);

  logic [31:0] crc_mid;

  assign crc_mid  = {1'b0, crc[31:1]} ^ ((crc[0] ^ dibit[0]) ? CRC32_POLY : 32'h0);
  assign crc_next = {1'b0, crc_mid[31:1]} ^ ((crc_mid[0] ^ dibit[1]) ? CRC32_POLY : 32'h0);

endmodule

// File: rtl/fcs_append.sv
// rtl/fcs_append.sv - appends Ethernet FCS to an RMII dibit stream and enforces the IFG
// Optional minimum-length zero padding is enabled by defining FCS_APPEND_PAD_EN.
module fcs_append
  import eth_pkg::*;
#(
  parameter int MIN_DIBITS = 240,
  parameter int IFG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       err
);

`ifdef FCS_APPEND_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [11:0] MIN_CNT  = 12'(MIN_DIBITS);
  localparam logic [11:0] GAP_LAST = 12'(IFG_DIBITS - 1);
  localparam logic [3:0]  FCS_LAST = 4'(FCS_DIBITS - 1);

  state_t      state;
  logic [11:0] cnt;
  logic [11:0] gap_cnt;
  logic [31:0] crc;
  logic [31:0] crc_base;
  logic [31:0] crc_upd;
  logic [1:0]  crc_din;
  logic [3:0]  fcs_idx;
  logic        drop;
  logic        axiiv_q;
  logic        pad_more;
  logic        intruder;

  // The first dibit of a frame is folded into the init value in the same cycle it is captured.
  assign crc_base = (state == IDLE) ? CRC32_INIT : crc;
  assign crc_din  = (axiiv && (state == IDLE || state == DATA)) ? axiid : 2'b00;
  assign pad_more = PAD_EN && (cnt < MIN_CNT);
  assign intruder = axiiv && (state == PAD || state == FCS || state == GAP);

  crc32_dibit u_crc (
    .crc      (crc_base),
    .dibit    (crc_din),
    .crc_next (crc_upd)
  );

  always_ff @(posedge clk) begin
    // Not reset: a frame still in flight across reset must be seen to end before a new one starts.
    axiiv_q <= axiiv;
    if (rst) begin
      state   <= IDLE;
      axiov   <= 1'b0;
      axiod   <= 2'b00;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= 12'd0;
      gap_cnt <= 12'd0;
      crc     <= CRC32_INIT;
      fcs_idx <= 4'd0;
      drop    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          axiov <= 1'b0;
          axiod <= 2'b00;
          if (axiiv && !axiiv_q && !drop) begin
            state <= DATA;
            axiov <= 1'b1;
            axiod <= axiid;
            crc   <= crc_upd;
            cnt   <= 12'd1;
          end else if (!axiiv) begin
            drop <= 1'b0;
          end
        end
        DATA: begin
          axiov <= 1'b1;
          if (axiiv) begin
            axiod <= axiid;
            crc   <= crc_upd;
            if (cnt != CNT_MAX) cnt <= cnt + 12'd1;
          end else if (pad_more) begin
            axiod <= 2'b00;
            crc   <= crc_upd;
            cnt   <= cnt + 12'd1;
            state <= PAD;
          end else begin
            axiod   <= ~crc[1:0];
            fcs_idx <= 4'd1;
            state   <= FCS;
          end
        end
`ifdef FCS_APPEND_PAD_EN
        PAD: begin
          axiov <= 1'b1;
          if (cnt < MIN_CNT) begin
            axiod <= 2'b00;
            crc   <= crc_upd;
            cnt   <= cnt + 12'd1;
          end else begin
            axiod   <= ~crc[1:0];
            fcs_idx <= 4'd1;
            state   <= FCS;
          end
        end
`endif
        FCS: begin
          axiov   <= 1'b1;
          axiod   <= ~crc[{fcs_idx, 1'b0} +: 2];
          fcs_idx <= fcs_idx + 4'd1;
          if (fcs_idx == FCS_LAST) begin
            done    <= 1'b1;
            gap_cnt <= 12'd0;
            state   <= GAP;
          end
        end
        GAP: begin
          axiov   <= 1'b0;
          axiod   <= 2'b00;
          gap_cnt <= gap_cnt + 12'd1;
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
        default: begin
          axiov <= 1'b0;
          axiod <= 2'b00;
          state <= IDLE;
        end
      endcase
      // A frame arriving while this one is still being finished is dropped whole, flagged once.
      if (intruder) begin
        err  <= !drop;
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fcs_append.md
FCS_APPEND -- requirements
Module: fcs_append

Interface
REQ-001 SHALL have parameter MIN_DIBITS, default 240, minimum pre-FCS frame length in dibits (60 bytes).
REQ-002 SHALL have parameter IFG_DIBITS, default 48, enforced inter-frame gap in cycles (96 bit times).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the 50 MHz RMII reference clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port axiiv, input, 1, input dibit valid; one contiguous high run equals one frame (destination MAC through payload, wire bit order).
REQ-007 SHALL have port axiid, input, 2, input dibit; bit 0 is the first bit on the wire.
REQ-008 SHALL have port axiov, output, 1, output dibit valid, for connection to the transmit framer.
REQ-009 SHALL have port axiod, output, 2, output dibit.
REQ-010 SHALL have port done, output, 1, one-cycle pulse coincident with the last FCS dibit.
REQ-011 SHALL have port err, output, 1, one-cycle pulse when an input frame is dropped.

Function
REQ-012 SHALL run a state machine with states IDLE, DATA, PAD, FCS and GAP.
REQ-013 IDLE->DATA SHALL occur on axiiv=1; the first dibit SHALL be captured in the same cycle.
REQ-014 In DATA, each input dibit SHALL appear on axiod with axiov=1 exactly one cycle later; no bubbles, no backpressure.
REQ-015 The CRC-32 SHALL use the reflected polynomial 0xEDB88320 and be initialised to 0xFFFFFFFF at frame start.
REQ-016 The CRC SHALL be updated 2 bits per cycle, bit 0 first, over every emitted data and pad dibit.
REQ-017 SHALL count emitted dibits in a counter at least 12 bits wide that saturates at 4095.
REQ-018 When axiiv falls in DATA, the next state SHALL be PAD if the count is below MIN_DIBITS (macro enabled), else FCS.
REQ-019 PAD SHALL emit 2'b00 dibits with axiov=1 until the count reaches MIN_DIBITS, then enter FCS.
REQ-020 FCS SHALL emit 16 dibits; dibit k (k=0..15) SHALL be ~crc[2k+1:2k] of the final CRC, with axiov continuously high.
REQ-021 The data-to-pad-to-FCS transition SHALL be seamless: axiov stays high for the whole frame.
REQ-022 done SHALL pulse with FCS dibit 15; FCS->GAP SHALL follow on the next cycle.
REQ-023 GAP SHALL hold axiov=0 for IFG_DIBITS cycles, then return to IDLE.
REQ-024 axiov SHALL be 0 in IDLE and GAP; axiod SHALL be 2'b00 whenever axiov=0.
REQ-025 If axiiv is high in FCS, PAD or GAP, or is still high on return to IDLE, those dibits SHALL be discarded.
REQ-026 In that case err SHALL pulse once and the block SHALL wait for axiiv=0 before accepting a new frame.
REQ-027 A single-dibit frame SHALL be legal and SHALL be padded and/or followed by FCS normally.

Reset
REQ-028 On rst: state=IDLE, axiov=0, axiod=0, done=0, err=0, counter=0, CRC=0xFFFFFFFF, drop flag cleared.
REQ-029 Reset mid-frame SHALL abort immediately with no FCS emitted; the next frame SHALL be accepted only after axiiv has been low for one cycle.

Configuration
REQ-030 Macro FCS_APPEND_PAD_EN defined: PAD state present and frames shorter than MIN_DIBITS are zero-padded.
REQ-031 Macro FCS_APPEND_PAD_EN undefined: PAD state is not compiled in; DATA always goes directly to FCS; MIN_DIBITS is ignored.

Structure
REQ-032 Package eth_pkg SHALL hold the state enum, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3 and FCS_DIBITS=16.
REQ-033 Sub-module crc32_dibit SHALL be a combinational 2-bit CRC next-state function, instantiated once.

Verification
REQ-034 Without macro, 9-byte "123456789" (36 dibits): axiov high 52 cycles; FCS bytes 26 39 F4 CB; first FCS dibit 2'b10; done on cycle 52.
REQ-035 With macro, same input: 240 data/pad dibits (204 of them 2'b00) plus 16 FCS dibits; CRC-32 over the whole output equals residue 0xDEBB20E3.
REQ-036 Back-to-back frames: second axiiv asserted 10 cycles after done: err=1 and no output; third frame sent after 48-cycle gap: transmitted correctly.
REQ-037 rst asserted at dibit 20 of a 100-dibit frame: axiov=0 next cycle with no FCS; the following 64-byte frame carries a correct FCS.
REQ-038 Single-dibit frame 2'b11 (macro undefined): axiov high exactly 17 cycles and output residue check passes.
